// File: rtl/ctrl_pkg.sv
// ctrl_pkg: state encodings, opcodes and mux/ALU select codes shared by the multi-cycle control
package ctrl_pkg;
    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        EXEC_R    = 4'd2,
        EXEC_I    = 4'd3,
        ALU_WB    = 4'd4,
        MEM_ADDR  = 4'd5,
        MEM_READ  = 4'd6,
        MEM_WB    = 4'd7,
        MEM_WRITE = 4'd8,
        BRANCH    = 4'd9,
        HALT      = 4'd10
    } state_t;
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
    localparam logic [1:0] ALU_SRC_A_PC     = 2'b00;
    localparam logic [1:0] ALU_SRC_A_PC_OLD = 2'b01;
    localparam logic [1:0] ALU_SRC_A_RS1    = 2'b10;
    localparam logic [1:0] ALU_SRC_B_RS2    = 2'b00;
    localparam logic [1:0] ALU_SRC_B_4      = 2'b01;
    localparam logic [1:0] ALU_SRC_B_IMM    = 2'b10;
endpackage

// File: rtl/ctrl_watchdog.sv
// ctrl_watchdog: counts data-memory wait cycles and flags the cycle that exhausts the budget
//   clock, reset : clock and asynchronous active-high reset
//   clr          : hold the counter at zero (outside memory states)
//   en           : this cycle is a wait cycle (memory state, mem_ready low)
//   timeout      : this wait cycle is the MEM_TIMEOUT-th consecutive one
module ctrl_watchdog #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic timeout
);
    localparam int W = $clog2(MEM_TIMEOUT + 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= cnt + W'(1);
    end
    assign timeout = en && cnt == W'(MEM_TIMEOUT - 1);
endmodule

// File: rtl/controle_multiciclo.sv
// controle_multiciclo: multi-cycle RV32I-subset control FSM with memory wait-states and halt/illegal detection
//   clock, reset : clock and asynchronous active-high reset
//   instrucao    : IR contents; zero : ALU equality flag; mem_ready : data memory done
//   pc_en, pc_source, ir_write, alu_src_a, alu_src_b, alu_op, mem_read, mem_write,
//   reg_write, mem_to_reg : datapath controls; halted, erro : halt status; estado : state for debug
//   Optional CTRL_PERF_COUNT_EN adds ciclos/instrucoes performance counters.
module controle_multiciclo import ctrl_pkg::*; #(
    parameter int MEM_TIMEOUT = 15
`ifdef CTRL_PERF_COUNT_EN
    , parameter int CONT_WIDTH = 32
`endif
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instrucao,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        pc_source,
    output logic        ir_write,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        halted,
    output logic        erro,
    output logic [3:0]  estado
`ifdef CTRL_PERF_COUNT_EN
    , output logic [CONT_WIDTH-1:0] ciclos
    , output logic [CONT_WIDTH-1:0] instrucoes
`endif
);
    state_t state, next;
    logic err_next, mem_st, wd_clr, wd_en, tmo;
    logic [6:0] opcode;
    assign opcode = instrucao[6:0];
    assign mem_st = state == MEM_READ || state == MEM_WRITE;
    assign wd_clr = !mem_st;
    assign wd_en  = mem_st && !mem_ready;
    ctrl_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_watchdog (
        .clock(clock),
        .reset(reset),
        .clr(wd_clr),
        .en(wd_en),
        .timeout(tmo)
    );
    always_comb begin
        next = state;
        err_next = 1'b0;
        case (state)
            FETCH: next = DECODE;
            DECODE: begin
                if (instrucao == 32'd0) next = HALT;
                else if (opcode == OP_R) next = EXEC_R;
                else if (opcode == OP_I) next = EXEC_I;
                else if (opcode == OP_LW || opcode == OP_SW) next = MEM_ADDR;
                else if (opcode == OP_BR) next = BRANCH;
                else begin
                    next = HALT;
                    err_next = 1'b1;
                end
            end
            EXEC_R, EXEC_I: next = ALU_WB;
            ALU_WB, MEM_WB, BRANCH: next = FETCH;
            MEM_ADDR: next = opcode == OP_SW ? MEM_WRITE : MEM_READ;
            // mem_ready has priority: tmo only fires on a cycle with mem_ready low
            MEM_READ: begin
                next = mem_ready ? MEM_WB : tmo ? HALT : MEM_READ;
                err_next = tmo;
            end
            MEM_WRITE: begin
                next = mem_ready ? FETCH : tmo ? HALT : MEM_WRITE;
                err_next = tmo;
            end
            default: next = HALT;
        endcase
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= FETCH;
            erro <= 1'b0;
`ifdef CTRL_PERF_COUNT_EN
            ciclos <= '0;
            instrucoes <= '0;
`endif
        end else begin
            state <= next;
            if (err_next) erro <= 1'b1;
`ifdef CTRL_PERF_COUNT_EN
            if (state != HALT) begin
                ciclos <= ciclos + CONT_WIDTH'(1);
                if (next == FETCH && (state == ALU_WB || state == MEM_WB || state == MEM_WRITE || state == BRANCH))
                    instrucoes <= instrucoes + CONT_WIDTH'(1);
            end
`endif
        end
    end
    // state resets to FETCH, so strobes are gated by reset to keep FETCH's enables quiet while it is held
    assign pc_en      = !reset && (state == FETCH || (state == BRANCH && zero));
    assign pc_source  = !reset && state == BRANCH;
    assign ir_write   = !reset && state == FETCH;
    assign alu_src_a  = reset ? ALU_SRC_A_PC :
                        state == DECODE ? ALU_SRC_A_PC_OLD :
                        (state == EXEC_R || state == EXEC_I || state == MEM_ADDR || state == BRANCH) ? ALU_SRC_A_RS1 :
                        ALU_SRC_A_PC;
    assign alu_src_b  = reset ? ALU_SRC_B_RS2 :
                        state == FETCH ? ALU_SRC_B_4 :
                        (state == DECODE || state == EXEC_I || state == MEM_ADDR) ? ALU_SRC_B_IMM :
                        ALU_SRC_B_RS2;
    assign alu_op     = reset ? ALU_OP_ADD :
                        (state == EXEC_R || state == EXEC_I) ? ALU_OP_FUNCT :
                        state == BRANCH ? ALU_OP_SUB : ALU_OP_ADD;
    assign mem_read   = !reset && state == MEM_READ;
    assign mem_write  = !reset && state == MEM_WRITE;
    assign reg_write  = !reset && (state == ALU_WB || state == MEM_WB);
    assign mem_to_reg = !reset && state == MEM_WB;
    assign halted     = !reset && state == HALT;
    assign estado     = state;
endmodule

// File: tb/tb_controle_multiciclo.sv
// tb_controle_multiciclo: directed scoreboard bench for the multi-cycle control FSM
module tb_controle_multiciclo;
    typedef logic [18:0] vec_t;
    // {pc_en, pc_source, ir_write, src_a, src_b, alu_op, mem_read, mem_write, reg_write, mem_to_reg, halted, erro, estado}
    localparam vec_t V_Z   = 19'd0;
    localparam vec_t V_F   = {1'b1, 1'b0, 1'b1, 2'b00, 2'b01, 2'b00, 4'b0000, 2'b00, 4'd0};
    localparam vec_t V_D   = {1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00, 4'b0000, 2'b00, 4'd1};
    localparam vec_t V_ER  = {1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 4'b0000, 2'b00, 4'd2};
    localparam vec_t V_EI  = {1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 2'b10, 4'b0000, 2'b00, 4'd3};
    localparam vec_t V_AW  = {1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 4'b0010, 2'b00, 4'd4};
    localparam vec_t V_MA  = {1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 2'b00, 4'b0000, 2'b00, 4'd5};
    localparam vec_t V_MR  = {1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 4'b1000, 2'b00, 4'd6};
    localparam vec_t V_MB  = {1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 4'b0011, 2'b00, 4'd7};
    localparam vec_t V_MW  = {1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 4'b0100, 2'b00, 4'd8};
    localparam vec_t V_BT  = {1'b1, 1'b1, 1'b0, 2'b10, 2'b00, 2'b01, 4'b0000, 2'b00, 4'd9};
    localparam vec_t V_BN  = {1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b01, 4'b0000, 2'b00, 4'd9};
    localparam vec_t V_H0  = {1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 4'b0000, 2'b10, 4'd10};
    localparam vec_t V_H1  = {1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 4'b0000, 2'b11, 4'd10};
    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_LW   = 32'h00002203;
    localparam logic [31:0] I_SW   = 32'h00202023;
    localparam logic [31:0] I_BEQT = 32'h00108463;
    localparam logic [31:0] I_BEQN = 32'h00208463;
    localparam logic [31:0] I_ILL  = 32'h0000007F;

    logic clock, reset, zero, mem_ready;
    logic [31:0] instrucao;
    logic pc_en, pc_source, ir_write, mem_read, mem_write, reg_write, mem_to_reg, halted, erro;
    logic [1:0] alu_src_a, alu_src_b, alu_op;
    logic [3:0] estado;
`ifdef CTRL_PERF_COUNT_EN
    logic [31:0] ciclos, instrucoes;
`endif
    int total = 0;
    int bad = 0;
    vec_t exp_q[$];
    string nm_q[$];

    controle_multiciclo dut (
        .clock(clock), .reset(reset), .instrucao(instrucao), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .pc_source(pc_source), .ir_write(ir_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .halted(halted), .erro(erro), .estado(estado)
`ifdef CTRL_PERF_COUNT_EN
        , .ciclos(ciclos), .instrucoes(instrucoes)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            vec_t e, got;
            string n;
            e = exp_q.pop_front();
            n = nm_q.pop_front();
            got = {pc_en, pc_source, ir_write, alu_src_a, alu_src_b, alu_op,
                   mem_read, mem_write, reg_write, mem_to_reg, halted, erro, estado};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL %s got=%05h exp=%05h (t=%0t)", n, got, e, $time);
            end
        end
    end

    task automatic step(input logic r, input logic [31:0] ins, input logic z, input logic rdy,
                        input vec_t v, input string n);
        @(posedge clock);
        #1;
        reset = r;
        instrucao = ins;
        zero = z;
        mem_ready = rdy;
        exp_q.push_back(v);
        nm_q.push_back(n);
    endtask

    initial begin
        reset = 1'b1;
        instrucao = 32'd0;
        zero = 1'b0;
        mem_ready = 1'b0;
        step(1, 0, 0, 0, V_Z, "reset");
        step(0, I_ADD, 0, 0, V_F, "add_fetch");
        step(0, I_ADD, 0, 0, V_D, "add_decode");
        step(0, I_ADD, 0, 0, V_ER, "add_exec");
        step(0, I_ADD, 0, 0, V_AW, "add_wb");
        step(0, I_ADDI, 0, 0, V_F, "addi_fetch");
        step(0, I_ADDI, 0, 0, V_D, "addi_decode");
        step(0, I_ADDI, 0, 0, V_EI, "addi_exec");
        step(0, I_ADDI, 0, 0, V_AW, "addi_wb");
        step(0, I_LW, 0, 0, V_F, "lw_fetch");
        step(0, I_LW, 0, 0, V_D, "lw_decode");
        step(0, I_LW, 0, 0, V_MA, "lw_addr");
        for (int i = 0; i < 3; i++) step(0, I_LW, 0, 0, V_MR, "lw_wait");
        step(0, I_LW, 0, 1, V_MR, "lw_ready");
        step(0, I_LW, 0, 0, V_MB, "lw_wb");
        step(0, I_SW, 0, 0, V_F, "sw_fetch");
        step(0, I_SW, 0, 0, V_D, "sw_decode");
        step(0, I_SW, 0, 0, V_MA, "sw_addr");
        step(0, I_SW, 0, 1, V_MW, "sw_write");
        step(0, I_BEQT, 1, 0, V_F, "beqt_fetch");
        step(0, I_BEQT, 1, 0, V_D, "beqt_decode");
        step(0, I_BEQT, 1, 0, V_BT, "beq_taken");
        step(0, I_BEQN, 0, 0, V_F, "beqn_fetch");
        step(0, I_BEQN, 0, 0, V_D, "beqn_decode");
        step(0, I_BEQN, 0, 0, V_BN, "beq_not_taken");
        step(0, I_LW, 0, 0, V_F, "lw14_fetch");
        step(0, I_LW, 0, 0, V_D, "lw14_decode");
        step(0, I_LW, 0, 0, V_MA, "lw14_addr");
        for (int i = 0; i < 14; i++) step(0, I_LW, 0, 0, V_MR, "lw14_wait");
        step(0, I_LW, 0, 1, V_MR, "lw14_ready");
        step(0, I_LW, 0, 0, V_MB, "lw14_wb");
        step(0, I_SW, 0, 0, V_F, "swto_fetch");
        step(0, I_SW, 0, 0, V_D, "swto_decode");
        step(0, I_SW, 0, 0, V_MA, "swto_addr");
        for (int i = 0; i < 15; i++) step(0, I_SW, 0, 0, V_MW, "swto_wait");
        step(0, I_SW, 0, 1, V_H1, "swto_halt");
        step(0, I_SW, 0, 1, V_H1, "swto_halt_hold");
        step(1, 0, 0, 0, V_Z, "reset_after_to");
        step(0, 0, 0, 0, V_F, "zero_fetch");
        step(0, 0, 0, 0, V_D, "zero_decode");
        step(0, 0, 0, 0, V_H0, "zero_halt");
        step(0, I_ADD, 0, 1, V_H0, "zero_halt_hold");
        step(1, 0, 0, 0, V_Z, "reset_after_zero");
        step(0, I_ILL, 0, 0, V_F, "ill_fetch");
        step(0, I_ILL, 0, 0, V_D, "ill_decode");
        step(0, I_ILL, 0, 0, V_H1, "ill_halt");
        step(0, I_ADD, 0, 0, V_H1, "ill_halt_hold");
        step(1, 0, 0, 0, V_Z, "reset_after_ill");
        step(0, I_LW, 0, 0, V_F, "lwrst_fetch");
        step(0, I_LW, 0, 0, V_D, "lwrst_decode");
        step(0, I_LW, 0, 0, V_MA, "lwrst_addr");
        step(0, I_LW, 0, 0, V_MR, "lwrst_wait");
        step(1, I_LW, 0, 1, V_Z, "mid_reset");
        step(1, I_LW, 0, 1, V_Z, "mid_reset_hold");
        step(0, I_ADD, 0, 0, V_F, "post_reset_fetch");
        step(0, I_ADD, 0, 0, V_D, "post_reset_decode");
        step(0, I_ADD, 0, 0, V_ER, "post_reset_exec");
        @(negedge clock);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
